pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameters: NUM_STAGES, default 5, number of sequenced stages (2..16); TIMEOUT_W, default 16, watchdog counter width; FRAME_CNT_W, default 8, frame counter width; IDX_W = $clog2(NUM_STAGES), derived.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous active-high reset
- enable  input  1  level; 1 = run frames continuously, 0 = stop/abort
- stage_bypass  input  NUM_STAGES  bit i=1 skips stage i
- timeout_limit  input  TIMEOUT_W  max cycles per stage; 0 = watchdog off
- clear_error  input  1  single-cycle pulse, leaves ERROR
- stage_done  input  NUM_STAGES  bit i = stage i finished
- stage_enable  output  NUM_STAGES  one-hot or zero, registered
- busy  output  1  high in RUN
- frame_done  output  1  one-cycle pulse per completed frame
- frame_count  output  FRAME_CNT_W  completed frames, wraps
- error  output  1  sticky watchdog error
- error_stage  output  IDX_W  stage index that timed out

Function
REQ-004 SHALL implement states IDLE, RUN, DONE, ERROR; all outputs registered.
REQ-005 IDLE: stage_enable=0, busy=0; on enable=1, SHALL latch stage_bypass and timeout_limit into shadow registers and go RUN.
REQ-006 Entering RUN SHALL set cur_idx to the lowest non-bypassed index; stage_enable[cur_idx]=1 on the first RUN cycle (one cycle after enable sampled high).
REQ-007 If all shadow bypass bits are 1, SHALL go IDLE->DONE directly with no stage enabled.
REQ-008 RUN: stage_done[cur_idx]=1 sampled at an edge SHALL advance cur_idx to the next higher non-bypassed index; old enable drops and new enable rises on the same edge (no gap cycle).
REQ-009 stage_done bits for indices other than cur_idx SHALL be ignored.
REQ-010 stage_done[cur_idx] on the highest non-bypassed stage SHALL move to DONE; stage_enable=0 in DONE.
REQ-011 DONE SHALL last exactly one cycle: frame_done=1, frame_count increments (wraps at 2^FRAME_CNT_W-1 -> 0).
REQ-012 From DONE: enable=1 -> re-latch bypass/timeout, RUN from first non-bypassed stage; enable=0 -> IDLE.
REQ-013 Watchdog: cycle counter clears on every stage entry, increments each RUN cycle; when shadow limit!=0 and counter reaches limit-1 with stage_done[cur_idx]=0, SHALL go ERROR next edge.
REQ-014 stage_done[cur_idx] in the same cycle as the timeout condition SHALL win (advance, no error).
REQ-015 ERROR: stage_enable=0, busy=0, error=1, error_stage=cur_idx at timeout; held until clear_error=1 -> IDLE, error=0.
REQ-016 enable=0 sampled in RUN SHALL abort: IDLE next edge, stage_enable=0, no frame_done, frame_count unchanged.
REQ-017 Changes to stage_bypass/timeout_limit mid-frame SHALL have no effect until next frame start.
REQ-018 clear_error outside ERROR SHALL be ignored; enable in ERROR SHALL be ignored.

Reset
REQ-019 reset=1 at any edge SHALL force IDLE, stage_enable=0, busy=0, frame_done=0, frame_count=0, error=0, error_stage=0, counters and shadows 0, overriding all other inputs including mid-frame.

Verification
REQ-020 Defaults, bypass=0, limit=0: enable=1, pulse stage_done[i] 2 cycles after each enable rises -> enables 00001,00010,00100,01000,10000 in order, one frame_done, frame_count=1.
REQ-021 bypass=5'b01010: enable held -> only stages 0,2,4 enabled; stage_done[1] pulses ignored; enable held after DONE -> second frame starts next cycle, frame_count=2.
REQ-022 limit=8, stage 2 never done -> error=1, error_stage=2, stage_enable=0 8 cycles after stage 2 entry; clear_error -> IDLE, error=0.
REQ-023 limit=4, stage_done[0] in the timeout cycle -> advance to stage 1, error stays 0.
REQ-024 enable=0 during stage 3 -> IDLE next edge, no frame_done; reset during stage 1 -> all outputs 0, frame_count=0.
REQ-025 bypass=5'b11111, enable=1 -> frame_done every 2 cycles, stage_enable always 0; frame_count wraps 255->0 with FRAME_CNT_W=8.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//   Runs a frame through NUM_STAGES stages one at a time. Each frame starts by
//   latching the bypass mask and watchdog limit. The sequencer then enables
//   each non-bypassed stage in ascending order and waits for that stage's
//   done bit. It reports the completed frame with a one-cycle pulse. A stage
//   that exceeds the watchdog limit parks the sequencer in a sticky error
//   state until clear_error.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   enable         1 = run frames back to back, 0 = stop / abort current frame
//   stage_bypass   bit i = 1 skips stage i (sampled at frame start)
//   timeout_limit  max cycles per stage, 0 disables the watchdog (frame start)
//   clear_error    pulse that leaves the error state
//   stage_done     bit i = stage i finished; only the active stage's bit counts
//   stage_enable   one-hot enable of the active stage, zero otherwise
//   busy           high while a frame is running
//   frame_done     one-cycle pulse per completed frame
//   frame_count    completed frames, wrapping
//   error          sticky watchdog error
//   error_stage    index of the stage that timed out
module pipeline_sequencer #(
  parameter int NUM_STAGES  = 5,
  parameter int TIMEOUT_W   = 16,
  parameter int FRAME_CNT_W = 8,
  parameter int IDX_W       = $clog2(NUM_STAGES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_STAGES-1:0]  stage_bypass,
  input  logic [TIMEOUT_W-1:0]   timeout_limit,
  input  logic                   clear_error,
  input  logic [NUM_STAGES-1:0]  stage_done,
  output logic [NUM_STAGES-1:0]  stage_enable,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   error,
  output logic [IDX_W-1:0]       error_stage
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERROR} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        cur_idx;
  logic [TIMEOUT_W-1:0]    wd_cnt;
  logic [NUM_STAGES-1:0]   bypass_shadow;
  logic [TIMEOUT_W-1:0]    limit_shadow;

  // {found, index} of the lowest non-bypassed stage at or above 'from'.
  // Scanning downward lets the lowest match overwrite any higher one.
  function automatic logic [IDX_W:0] find_stage(input logic [NUM_STAGES-1:0] byp,
                                                input int from);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i >= from && !byp[i]) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  logic [IDX_W:0] first_pick;  // first stage of a frame starting now (live mask)
  logic [IDX_W:0] adv_pick;    // next stage after the current one (frame mask)
  logic           cur_done;
  logic           wd_expired;

  always_comb begin
    first_pick = find_stage(stage_bypass, 0);
    adv_pick   = find_stage(bypass_shadow, int'(cur_idx) + 1);
    cur_done   = stage_done[cur_idx];
    wd_expired = (limit_shadow != '0) && (wd_cnt == limit_shadow - TIMEOUT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cur_idx       <= '0;
      wd_cnt        <= '0;
      bypass_shadow <= '0;
      limit_shadow  <= '0;
      stage_enable  <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      error         <= 1'b0;
      error_stage   <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (enable) begin
            bypass_shadow <= stage_bypass;
            limit_shadow  <= timeout_limit;
            wd_cnt        <= '0;
            if (first_pick[IDX_W]) begin
              state        <= ST_RUN;
              cur_idx      <= first_pick[IDX_W-1:0];
              stage_enable <= NUM_STAGES'(1) << first_pick[IDX_W-1:0];
              busy         <= 1'b1;
            end else if (state == ST_IDLE) begin
              // Empty frame: completes immediately.
              state       <= ST_DONE;
              frame_done  <= 1'b1;
              frame_count <= frame_count + FRAME_CNT_W'(1);
            end else begin
              // An empty frame right after DONE passes through IDLE first,
              // so DONE stays a single cycle and frames are spaced 2 apart.
              state <= ST_IDLE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          if (!enable) begin
            state        <= ST_IDLE;
            stage_enable <= '0;
            busy         <= 1'b0;
          end else if (cur_done) begin
            // A done bit on the watchdog's last cycle still advances.
            wd_cnt <= '0;
            if (adv_pick[IDX_W]) begin
              cur_idx      <= adv_pick[IDX_W-1:0];
              stage_enable <= NUM_STAGES'(1) << adv_pick[IDX_W-1:0];
            end else begin
              state        <= ST_DONE;
              stage_enable <= '0;
              busy         <= 1'b0;
              frame_done   <= 1'b1;
              frame_count  <= frame_count + FRAME_CNT_W'(1);
            end
          end else if (wd_expired) begin
            state        <= ST_ERROR;
            stage_enable <= '0;
            busy         <= 1'b0;
            error        <= 1'b1;
            error_stage  <= cur_idx;
          end else begin
            wd_cnt <= wd_cnt + TIMEOUT_W'(1);
          end
        end

        ST_ERROR: begin
          // error_stage is left holding the last failing index for inspection.
          if (clear_error) begin
            state <= ST_IDLE;
            error <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [4:0]  stage_bypass;
  logic [15:0] timeout_limit;
  logic        clear_error;
  logic [4:0]  stage_done;
  logic [4:0]  stage_enable;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        error;
  logic [2:0]  error_stage;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .stage_bypass (stage_bypass),
    .timeout_limit(timeout_limit),
    .clear_error  (clear_error),
    .stage_done   (stage_done),
    .stage_enable (stage_enable),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .error        (error),
    .error_stage  (error_stage)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [4:0]  byp;
    logic [15:0] lim;
    logic        clr;
    logic [4:0]  done;
    logic [4:0]  e_se;
    logic        e_busy;
    logic        e_fd;
    logic [7:0]  e_fc;
    logic        e_err;
    logic [2:0]  e_es;
  } vec_t;

  vec_t vec_q[$];

  function automatic void add(input logic rst, input logic en, input logic [4:0] byp,
                              input logic [15:0] lim, input logic clr, input logic [4:0] done,
                              input logic [4:0] se, input logic bsy, input logic fd,
                              input logic [7:0] fc, input logic err, input logic [2:0] es);
    vec_t v;
    v.rst = rst; v.en = en; v.byp = byp; v.lim = lim; v.clr = clr; v.done = done;
    v.e_se = se; v.e_busy = bsy; v.e_fd = fd; v.e_fc = fc; v.e_err = err; v.e_es = es;
    vec_q.push_back(v);
  endfunction

  initial begin
    logic [18:0] act, exp_v;
    logic [15:0] act_w, exp_w;
    logic [7:0]  exp_fc;
    logic [7:0]  prev_fc;
    logic        wrapped;

    // rst en  byp      lim clr done       se       bsy fd fc err es
    // Plain frame, no bypass, watchdog off; stray done on stage 1 ignored.
    add(1, 0, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00000, 5'b00001, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00010, 5'b00001, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00001, 5'b00010, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00000, 5'b00010, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00010, 5'b00100, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00000, 5'b00100, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00100, 5'b01000, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00000, 5'b01000, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b01000, 5'b10000, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00000, 5'b10000, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b10000, 5'b00000, 0, 1, 1, 0, 0);
    add(0, 0, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 0, 1, 0, 0);
    // Bypass 01010: stages 0,2,4; mid-frame mask change ignored; back-to-back frame.
    add(0, 1, 5'b01010, 0, 0, 5'b00000, 5'b00001, 1, 0, 1, 0, 0);
    add(0, 1, 5'b01010, 0, 0, 5'b00010, 5'b00001, 1, 0, 1, 0, 0);
    add(0, 1, 5'b01010, 0, 0, 5'b00001, 5'b00100, 1, 0, 1, 0, 0);
    add(0, 1, 5'b10000, 0, 0, 5'b00010, 5'b00100, 1, 0, 1, 0, 0);
    add(0, 1, 5'b10000, 0, 0, 5'b00100, 5'b10000, 1, 0, 1, 0, 0);
    add(0, 1, 5'b01010, 0, 0, 5'b10000, 5'b00000, 0, 1, 2, 0, 0);
    add(0, 1, 5'b01010, 0, 0, 5'b00000, 5'b00001, 1, 0, 2, 0, 0);
    // Reset mid-frame, then reset during stage 1.
    add(1, 1, 5'b01010, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00000, 5'b00001, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00001, 5'b00010, 1, 0, 0, 0, 0);
    add(1, 1, 5'b00000, 0, 0, 5'b00010, 5'b00000, 0, 0, 0, 0, 0);
    add(0, 0, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
    // Abort during stage 3: no frame_done, count unchanged.
    add(0, 1, 5'b00000, 0, 0, 5'b00000, 5'b00001, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00001, 5'b00010, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00010, 5'b00100, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00100, 5'b01000, 1, 0, 0, 0, 0);
    add(0, 0, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
    add(0, 0, 5'b00000, 0, 0, 5'b01000, 5'b00000, 0, 0, 0, 0, 0);
    // Watchdog limit 8, stage 2 stalls; limit input zeroed mid-frame has no effect.
    add(0, 1, 5'b00000, 8, 0, 5'b00000, 5'b00001, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 8, 0, 5'b00001, 5'b00010, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 8, 0, 5'b00010, 5'b00100, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      add(0, 1, 5'b00000, 0, 0, 5'b00000, 5'b00100, 1, 0, 0, 0, 0);
    add(0, 1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 1, 2);
    add(0, 1, 5'b00000, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 1, 2);
    add(0, 0, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0, 2);
    add(0, 0, 5'b00000, 0, 1, 5'b00000, 5'b00000, 0, 0, 0, 0, 2);
    // Watchdog limit 4: done arrives in the expiry cycle and wins.
    add(0, 1, 5'b00000, 4, 0, 5'b00000, 5'b00001, 1, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++)
      add(0, 1, 5'b00000, 4, 0, 5'b00000, 5'b00001, 1, 0, 0, 0, 2);
    add(0, 1, 5'b00000, 4, 0, 5'b00001, 5'b00010, 1, 0, 0, 0, 2);
    add(0, 0, 5'b00000, 4, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 2);

    reset = 1'b1; enable = 1'b0; stage_bypass = '0; timeout_limit = '0;
    clear_error = 1'b0; stage_done = '0;

    foreach (vec_q[i]) begin
      @(negedge clk);
      reset = vec_q[i].rst; enable = vec_q[i].en; stage_bypass = vec_q[i].byp;
      timeout_limit = vec_q[i].lim; clear_error = vec_q[i].clr; stage_done = vec_q[i].done;
      @(posedge clk);
      #1;
      act   = {stage_enable, busy, frame_done, frame_count, error, error_stage};
      exp_v = {vec_q[i].e_se, vec_q[i].e_busy, vec_q[i].e_fd, vec_q[i].e_fc,
               vec_q[i].e_err, vec_q[i].e_es};
      n_checks++;
      if (act !== exp_v) begin
        n_fails++;
        $display("FAIL vec%0d: got se=%b busy=%b fd=%b fc=%0d err=%b es=%0d, expected se=%b busy=%b fd=%b fc=%0d err=%b es=%0d",
                 i, stage_enable, busy, frame_done, frame_count, error, error_stage,
                 vec_q[i].e_se, vec_q[i].e_busy, vec_q[i].e_fd, vec_q[i].e_fc,
                 vec_q[i].e_err, vec_q[i].e_es);
      end else begin
        $display("vec%0d ok: se=%b busy=%b fd=%b fc=%0d err=%b es=%0d",
                 i, stage_enable, busy, frame_done, frame_count, error, error_stage);
      end
    end

    // All stages bypassed: empty frames every 2 cycles, count wraps 255 -> 0.
    @(negedge clk);
    reset = 1'b0; enable = 1'b1; stage_bypass = 5'b11111; timeout_limit = '0;
    clear_error = 1'b0; stage_done = '0;
    exp_fc  = 8'd0;
    prev_fc = 8'd0;
    wrapped = 1'b0;
    for (int k = 1; k <= 520; k++) begin
      @(posedge clk);
      #1;
      if (k % 2 == 1) exp_fc = exp_fc + 8'd1;
      act_w = {stage_enable, busy, frame_done, frame_count, error};
      exp_w = {5'b00000, 1'b0, 1'(k % 2), exp_fc, 1'b0};
      n_checks++;
      if (act_w !== exp_w) begin
        n_fails++;
        $display("FAIL bypass_all k=%0d: got se=%b busy=%b fd=%b fc=%0d err=%b, expected se=00000 busy=0 fd=%0d fc=%0d err=0",
                 k, stage_enable, busy, frame_done, frame_count, error, k % 2, exp_fc);
      end else if (frame_done) begin
        $display("bypass_all k=%0d ok: frame_done fc=%0d", k, frame_count);
      end
      if (prev_fc == 8'd255 && frame_count == 8'd0) wrapped = 1'b1;
      prev_fc = frame_count;
    end
    n_checks++;
    if (wrapped !== 1'b1) begin
      n_fails++;
      $display("FAIL frame_count_wrap: got wrapped=%b, expected wrapped=1", wrapped);
    end else begin
      $display("frame_count_wrap ok");
    end

    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
